dac_tlv5618_rx: RTL and testbench
=================================

Name: dac_tlv5618_rx

Overview:
- Synthesizable serial responder for the TLV5618 3-wire write interface (cs_n / sclk / din).
- Oversamples the bus in the system clock domain, shifts in 16-bit frames and decodes the 4 control bits.
- Maintains the DAC A, DAC B and BUFFER registers and the SPD/PWR mode bits.
- Used as the loop-back target for the DAC transmitter on-chip and as a self-checking bus monitor in board bring-up.

Parameters:
- SyncStages, 2, number of synchronizer flops on each input pin (legal range 2..3).

Ports:
- clk  input  1  system clock; sclk half-period must be at least 2 clk cycles.
- rst  input  1  synchronous, active-high reset.
- dac_cs_n  input  1  chip select, active low; async to clk.
- dac_sclk  input  1  serial clock; async to clk.
- dac_din  input  1  serial data, MSB first, sampled on sclk falling edge.
- frame_valid  output  1  one-cycle pulse: a well-formed 16-bit frame was received.
- frame_err  output  1  one-cycle pulse: cs_n rose after a bit count other than 16.
- frame_data  output  16  last well-formed frame; updated together with frame_valid.
- dac_a  output  12  DAC A output register.
- dac_b  output  12  DAC B output register.
- buffer  output  12  double-buffer register.
- spd  output  1  speed bit from the last non-reserved frame.
- pwr  output  1  power-down bit from the last non-reserved frame.

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs are 0. Shift register and bit counter are 0.
  - Synchronizer chains load idle levels: cs_n=1, sclk=0, din=0.
- Synchronization and edge detection:
  - Each pin passes through SyncStages flops, then one "previous" flop.
  - An edge is the compare of the last stage against the previous flop.
- Frame start: a synced cs_n falling edge clears the bit counter and the shift register.
- Bit capture: on a synced sclk falling edge while synced cs_n is low:
  - Shift left and insert synced din at bit 0.
  - Increment the counter, saturating at 17. A value of 17 means overrun.
- sclk edges while cs_n is high are ignored.
- Frame end: evaluated on a synced cs_n rising edge.
  - count == 16: frame_valid pulses, frame_data <= shift register, and the frame is decoded.
  - Any other count (0..15 or 17): frame_err pulses. No register changes.
- Simultaneous events: if a synced sclk falling edge and a synced cs_n rising edge occur in the same cycle, the bit is captured first and the frame is evaluated including that bit.
- Decode fields: R1=D15, SPD=D14, PWR=D13, R0=D12, value=D11..D0.
- Decode actions by {R1,R0}:
  - 00: dac_b <= value; buffer <= value.
  - 01: buffer <= value only.
  - 10: dac_a <= value; dac_b <= buffer (the value before this frame).
  - 11: reserved. frame_valid and frame_data still update. dac_a, dac_b, buffer, spd and pwr are unchanged.
- spd and pwr load from D14 and D13 on every non-reserved valid frame.
- Latency: frame_valid, frame_err and all register updates appear exactly SyncStages+2 clk edges after the first clk edge that samples cs_n high at the pin.
- Reset mid-frame:
  - State clears.
  - If cs_n is still low at the pin, the synced 1->0 transition is treated as a frame start.
  - The partial frame then ends in frame_err; no register is corrupted.
- frame_valid and frame_err are never high in the same cycle.
- Back-to-back frames with cs_n high for at least 2 clk cycles are each processed independently.

Test Plan:
- Write 0x0456 (R=00), sclk half-period 2 clk -> frame_valid one pulse; dac_b=0x456, buffer=0x456, dac_a=0, spd=0, pwr=0; frame_data=0x0456.
- Write 0x1123 then 0x8ABC -> after frame 1, buffer=0x123 and dac_a/dac_b unchanged; after frame 2, dac_a=0xABC and dac_b=0x123; two frame_valid pulses.
- Write 0x6F00 (R1=0, SPD=1, PWR=1, R0=0) -> dac_b=0xF00, spd=1, pwr=1; then write 0x9FFF (reserved) -> frame_valid pulses, frame_data=0x9FFF, all other registers unchanged.
- Short frame (10 falling edges) and long frame (18 falling edges) -> frame_err one pulse each, no frame_valid, registers unchanged; a following good 0x8001 frame -> dac_a=0x001.
- Assert rst for 1 cycle after bit 7 of a frame while cs_n stays low -> all outputs 0, frame_err at cs_n rise, then next good frame decoded correctly.
- Check latency: frame_valid rises exactly SyncStages+2 clk edges after cs_n rises, for SyncStages=2 and 3; sclk edges while cs_n is high cause no counter change.

Source files
------------

// File: rtl/dac_tlv5618_rx.sv
// TLV5618 3-wire write-interface responder.
// Oversamples cs_n/sclk/din in the clk domain, shifts in 16-bit MSB-first frames
// and maintains the DAC A, DAC B, BUFFER registers and the SPD/PWR mode bits.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   dac_cs_n       chip select (active low, async)
//   dac_sclk       serial clock (async), data taken on falling edge
//   dac_din        serial data (async), MSB first
//   frame_valid    1-cycle pulse, well-formed 16-bit frame received
//   frame_err      1-cycle pulse, frame ended with a bit count other than 16
//   frame_data     last well-formed frame
//   dac_a, dac_b   DAC output registers
//   buffer         double-buffer register
//   spd, pwr       mode bits from the last non-reserved frame
module dac_tlv5618_rx #(
  parameter int unsigned SyncStages = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dac_cs_n,
  input  logic        dac_sclk,
  input  logic        dac_din,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] frame_data,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] buffer,
  output logic        spd,
  output logic        pwr
);

  logic [SyncStages-1:0] cs_sync_q, sclk_sync_q, din_sync_q;
  logic                  cs_prev_q, sclk_prev_q;
  logic                  cs_s, sclk_s, din_s;
  logic                  cs_fall, cs_rise, sclk_fall, capture;

  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;

  // Two-stage evaluation pipeline after the synced cs_n rise.
  logic        ev1_q, ev1_ok_q;
  logic [15:0] ev1_data_q;
  logic        ev2_q, ev2_ok_q;
  logic [15:0] ev2_data_q;

  logic        frame_valid_q, frame_err_q, spd_q, pwr_q;
  logic [15:0] frame_data_q;
  logic [11:0] dac_a_q, dac_b_q, buffer_q;

  assign cs_s   = cs_sync_q[SyncStages-1];
  assign sclk_s = sclk_sync_q[SyncStages-1];
  assign din_s  = din_sync_q[SyncStages-1];

  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  // Gate on the previous cs_n level so a bit landing with the cs_n rise is still taken.
  assign capture   = sclk_fall & ~cs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SyncStages-2:0], dac_cs_n};
      sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], dac_sclk};
      din_sync_q  <= {din_sync_q[SyncStages-2:0], dac_din};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (cs_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (capture) begin
      shift_d = {shift_q[14:0], din_s};
      // 17 marks overrun and sticks.
      if (cnt_q != 5'd17) begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      ev1_q      <= 1'b0;
      ev1_ok_q   <= 1'b0;
      ev1_data_q <= '0;
      ev2_q      <= 1'b0;
      ev2_ok_q   <= 1'b0;
      ev2_data_q <= '0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ev1_q      <= cs_rise;
      ev1_ok_q   <= cs_rise & (cnt_d == 5'd16);
      ev1_data_q <= shift_d;
      ev2_q      <= ev1_q;
      ev2_ok_q   <= ev1_ok_q;
      ev2_data_q <= ev1_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_data_q  <= '0;
      dac_a_q       <= '0;
      dac_b_q       <= '0;
      buffer_q      <= '0;
      spd_q         <= 1'b0;
      pwr_q         <= 1'b0;
    end else begin
      frame_valid_q <= ev2_q & ev2_ok_q;
      frame_err_q   <= ev2_q & ~ev2_ok_q;
      if (ev2_q && ev2_ok_q) begin
        frame_data_q <= ev2_data_q;
        unique case ({ev2_data_q[15], ev2_data_q[12]})
          2'b00: begin
            dac_b_q  <= ev2_data_q[11:0];
            buffer_q <= ev2_data_q[11:0];
          end
          2'b01: buffer_q <= ev2_data_q[11:0];
          2'b10: begin
            dac_a_q <= ev2_data_q[11:0];
            dac_b_q <= buffer_q;
          end
          2'b11: ;
        endcase
        if (!(ev2_data_q[15] && ev2_data_q[12])) begin
          spd_q <= ev2_data_q[14];
          pwr_q <= ev2_data_q[13];
        end
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_data  = frame_data_q;
  assign dac_a       = dac_a_q;
  assign dac_b       = dac_b_q;
  assign buffer      = buffer_q;
  assign spd         = spd_q;
  assign pwr         = pwr_q;

endmodule

// File: tb/tb_dac_tlv5618_rx.sv
// Bench for dac_tlv5618_rx: drives directed TLV5618 frames into two instances
// (SyncStages 2 and 3) and compares every cycle against a frame-level model.
module tb_dac_tlv5618_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n = 1'b1;
  logic sclk = 1'b0;
  logic din = 1'b0;

  logic        fv [2];
  logic        fe [2];
  logic [15:0] fd [2];
  logic [11:0] oa [2];
  logic [11:0] ob [2];
  logic [11:0] obf [2];
  logic        osp [2];
  logic        opw [2];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_tlv5618_rx #(.SyncStages(2)) u_dut2 (
    .clk(clk), .rst(rst), .dac_cs_n(cs_n), .dac_sclk(sclk), .dac_din(din),
    .frame_valid(fv[0]), .frame_err(fe[0]), .frame_data(fd[0]), .dac_a(oa[0]),
    .dac_b(ob[0]), .buffer(obf[0]), .spd(osp[0]), .pwr(opw[0])
  );

  dac_tlv5618_rx #(.SyncStages(3)) u_dut3 (
    .clk(clk), .rst(rst), .dac_cs_n(cs_n), .dac_sclk(sclk), .dac_din(din),
    .frame_valid(fv[1]), .frame_err(fe[1]), .frame_data(fd[1]), .dac_a(oa[1]),
    .dac_b(ob[1]), .buffer(obf[1]), .spd(osp[1]), .pwr(opw[1])
  );

  // Expected visible state after a frame and the cycle it must appear (SyncStages=2 base).
  typedef struct {
    int          due;
    bit          valid;
    logic [15:0] fd;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] bf;
    logic        spd;
    logic        pwr;
  } ev_t;

  ev_t evq[$];
  ev_t m;
  ev_t cur [2];
  int  ptr [2];

  function automatic ev_t zero_ev();
    ev_t z;
    z.due = 0; z.valid = 1'b0; z.fd = '0; z.a = '0; z.b = '0; z.bf = '0;
    z.spd = 1'b0; z.pwr = 1'b0;
    return z;
  endfunction

  task automatic chk(input string name, input int d, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s S%0d cyc=%0d got=%h want=%h", name, d + 2, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: called when cs_n is released at the pin.
  // First sampling edge is cyc+1; outputs show SyncStages+2 edges later.
  task automatic record(input logic [31:0] pat, input int nbits);
    ev_t e;
    logic [11:0] val;
    e = m;
    e.due = cyc + 1 + 2 + 2;
    e.valid = (nbits == 16);
    val = pat[11:0];
    if (e.valid) begin
      e.fd = pat[15:0];
      if (pat[15] == 1'b0 && pat[12] == 1'b0) begin
        e.b = val; e.bf = val;
      end else if (pat[15] == 1'b0) begin
        e.bf = val;
      end else if (pat[12] == 1'b0) begin
        e.a = val; e.b = m.bf;
      end
      if (!(pat[15] && pat[12])) begin
        e.spd = pat[14]; e.pwr = pat[13];
      end
    end
    m = e;
    evq.push_back(e);
  endtask

  task automatic send_bit(input logic b, input int half);
    din = b;
    sclk = 1'b1;
    tick(half);
    sclk = 1'b0;
    tick(half);
  endtask

  task automatic send_frame(input logic [31:0] pat, input int nbits, input int half);
    cs_n = 1'b0;
    tick(half);
    for (int i = 0; i < nbits; i++) send_bit(pat[nbits-1-i], half);
    cs_n = 1'b1;
    record(pat, nbits);
  endtask

  // Per-cycle compare of both instances against the model.
  initial begin
    cur[0] = zero_ev(); cur[1] = zero_ev();
    ptr[0] = 0; ptr[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur[0] = zero_ev(); cur[1] = zero_ev();
      end else begin
        for (int d = 0; d < 2; d++) begin
          logic ev_v, ev_e;
          ev_v = 1'b0; ev_e = 1'b0;
          if (ptr[d] < evq.size() && evq[ptr[d]].due + d == cyc) begin
            ev_v = evq[ptr[d]].valid;
            ev_e = !evq[ptr[d]].valid;
            cur[d] = evq[ptr[d]];
            ptr[d]++;
          end
          chk("frame_valid", d, {15'd0, fv[d]}, {15'd0, ev_v});
          chk("frame_err", d, {15'd0, fe[d]}, {15'd0, ev_e});
          chk("frame_data", d, fd[d], cur[d].fd);
          chk("dac_a", d, {4'd0, oa[d]}, {4'd0, cur[d].a});
          chk("dac_b", d, {4'd0, ob[d]}, {4'd0, cur[d].b});
          chk("buffer", d, {4'd0, obf[d]}, {4'd0, cur[d].bf});
          chk("spd", d, {15'd0, osp[d]}, {15'd0, cur[d].spd});
          chk("pwr", d, {15'd0, opw[d]}, {15'd0, cur[d].pwr});
        end
      end
    end
  end

  initial begin
    m = zero_ev();
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("lit_reset_dac_a", 0, {4'd0, oa[0]}, 16'h0000);
    chk("lit_reset_frame_data", 0, fd[0], 16'h0000);

    // Plain DAC B write.
    send_frame(32'h0456, 16, 2);
    tick(12);
    chk("lit_0456_dac_b", 0, {4'd0, ob[0]}, 16'h0456);
    chk("lit_0456_buffer", 0, {4'd0, obf[0]}, 16'h0456);
    chk("lit_0456_frame_data", 0, fd[0], 16'h0456);

    // Buffer write, then DAC A write with buffer transfer, back to back.
    send_frame(32'h1123, 16, 2);
    tick(2);
    send_frame(32'h8ABC, 16, 2);
    tick(12);
    chk("lit_8ABC_dac_a", 0, {4'd0, oa[0]}, 16'h0ABC);
    chk("lit_8ABC_dac_b", 0, {4'd0, ob[0]}, 16'h0123);

    // Mode bits, then reserved frame.
    send_frame(32'h6F00, 16, 2);
    tick(12);
    chk("lit_6F00_dac_b", 0, {4'd0, ob[0]}, 16'h0F00);
    chk("lit_6F00_spd", 0, {15'd0, osp[0]}, 16'h0001);
    chk("lit_6F00_pwr", 0, {15'd0, opw[0]}, 16'h0001);
    send_frame(32'h9FFF, 16, 2);
    tick(12);
    chk("lit_9FFF_frame_data", 0, fd[0], 16'h9FFF);
    chk("lit_9FFF_dac_a", 0, {4'd0, oa[0]}, 16'h0ABC);

    // Short and long frames, then a good DAC A write.
    send_frame(32'h0000_03A5, 10, 2);
    tick(10);
    send_frame(32'h0003_FFFF, 18, 2);
    tick(10);
    send_frame(32'h8001, 16, 2);
    tick(12);
    chk("lit_8001_dac_a", 0, {4'd0, oa[0]}, 16'h0001);
    chk("lit_8001_dac_b", 0, {4'd0, ob[0]}, 16'h0F00);

    // sclk activity with cs_n high must be ignored.
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b1; tick(2); sclk = 1'b0; tick(2);
    end
    tick(8);

    // Reset after bit 7 with cs_n held low.
    cs_n = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 2);
    tick(6);
    rst = 1'b1;
    m = zero_ev();
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("lit_rst_dac_a", 0, {4'd0, oa[0]}, 16'h0000);
    chk("lit_rst_spd", 0, {15'd0, osp[0]}, 16'h0000);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 2);
    cs_n = 1'b1;
    record(32'h0000_00FF, 8);
    tick(12);
    chk("lit_rst_dac_a_after_err", 0, {4'd0, oa[0]}, 16'h0000);

    // Good frame after reset, slower sclk.
    send_frame(32'h0ABC, 16, 3);
    tick(14);
    chk("lit_0ABC_dac_b", 0, {4'd0, ob[0]}, 16'h0ABC);
    chk("lit_0ABC_dac_b_s3", 1, {4'd0, ob[1]}, 16'h0ABC);

    tick(10);
    chk("events_seen", 0, 16'(ptr[0]), 16'(evq.size()));
    chk("events_seen", 1, 16'(ptr[1]), 16'(evq.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
